// File: rtl/pd_dw_mc_acc.sv
// rtl/pd_dw_mc_acc.sv - per-antenna power accumulator with per-symbol result RAM (peak-hold: PD_DW_MC_PEAK_HOLD_EN)
module pd_dw_mc_acc #(
  parameter int NANT    = 8,
  parameter int NSYM    = 14,
  parameter int NSLOT   = 10,
  parameter int SYM_LEN = 2048,
  parameter int IQ_W    = 16,
  localparam int DEPTH  = NANT * NSYM * NSLOT,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              i_fram,
  input  logic              i_xant,
  input  logic              i_vld,
  input  logic [2*IQ_W-1:0] i_data,
  input  logic              i_mode,
  input  logic              i_clr,
  input  logic [AW-1:0]     i_raddr,
  output logic [31:0]       o_rdata_lo,
  output logic [31:0]       o_rdata_hi,
  output logic              o_clr_busy,
  output logic              o_sym_done,
  output logic              o_sat
);

  localparam int ACC_W = 48;
  localparam int DW    = 2 * IQ_W;
  localparam int PW    = DW + 1;
  localparam int SUMW  = ((PW > ACC_W) ? PW : ACC_W) + 1;
  localparam int NW    = (NANT > 1) ? $clog2(NANT) : 1;
  localparam int SW    = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int LW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int CW    = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;

  localparam logic [NW-1:0]    ANT_LAST   = NW'(NANT - 1);
  localparam logic [SW-1:0]    SYM_LAST   = SW'(NSYM - 1);
  localparam logic [LW-1:0]    SLOT_LAST  = LW'(NSLOT - 1);
  localparam logic [CW-1:0]    CNT_LAST   = CW'(SYM_LEN - 1);
  localparam logic [AW-1:0]    DEPTH_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]      DEPTH_W    = (AW+1)'(DEPTH);
  localparam logic [ACC_W-1:0] ACC_MAX    = '1;

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef PD_DW_MC_PEAK_HOLD_EN
    S_RD,
`endif
    S_WR,
    S_DONE,
    S_CLR
  } state_t;

  // ---------------- stage 1: power, antenna / symbol bookkeeping ----------------
  logic signed [IQ_W-1:0] s_i, s_q;
  logic signed [DW-1:0]   e_i, e_q, sq_i, sq_q;
  logic [PW-1:0]          p_next;
  logic [NW-1:0]          ant_cnt, ant_base, ant_cur;
  logic [CW-1:0]          samp_cnt, cnt_cur;
  logic [SW-1:0]          sym_cnt, sym_cur;
  logic [LW-1:0]          slot_cnt, slot_cur;
  logic                   sym_end;
  logic [31:0]            base_full;

  assign s_i  = i_data[2*IQ_W-1:IQ_W];
  assign s_q  = i_data[IQ_W-1:0];
  assign e_i  = DW'(s_i);
  assign e_q  = DW'(s_q);
  assign sq_i = e_i * e_i;
  assign sq_q = e_q * e_q;
  assign p_next = PW'($unsigned(sq_i)) + PW'($unsigned(sq_q));

  // A frame pulse makes the current cycle behave as the first cycle of a fresh frame.
  assign ant_base  = i_fram ? '0 : ant_cnt;
  assign ant_cur   = i_xant ? '0 : ant_base;
  assign cnt_cur   = i_fram ? '0 : samp_cnt;
  assign sym_cur   = i_fram ? '0 : sym_cnt;
  assign slot_cur  = i_fram ? '0 : slot_cnt;
  assign sym_end   = (ant_cur == ANT_LAST) && (cnt_cur == CNT_LAST);
  assign base_full = (32'(slot_cur) * 32'(NSYM) + 32'(sym_cur)) * 32'(NANT);

  logic [PW-1:0] p_q;
  logic [NW-1:0] ant_q;
  logic          vld_q, last_q;
  logic [AW-1:0] base_q;
`ifdef PD_DW_MC_PEAK_HOLD_EN
  logic          mode_q;
`else
  logic          unused_mode;
  assign unused_mode = i_mode;
`endif

  // Register the sample power and advance antenna/sample/symbol/slot counters.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      p_q      <= '0;
      ant_q    <= '0;
      vld_q    <= 1'b0;
      last_q   <= 1'b0;
      base_q   <= '0;
      ant_cnt  <= '0;
      samp_cnt <= '0;
      sym_cnt  <= '0;
      slot_cnt <= '0;
`ifdef PD_DW_MC_PEAK_HOLD_EN
      mode_q   <= 1'b0;
`endif
    end else begin
      vld_q    <= i_vld;
      last_q   <= i_vld && sym_end;
      ant_cnt  <= ant_base;
      samp_cnt <= cnt_cur;
      sym_cnt  <= sym_cur;
      slot_cnt <= slot_cur;
      if (i_vld) begin
        p_q     <= p_next;
        ant_q   <= ant_cur;
        ant_cnt <= (ant_cur == ANT_LAST) ? '0 : ant_cur + NW'(1);
        if (ant_cur == ANT_LAST) begin
          if (cnt_cur == CNT_LAST) begin
            samp_cnt <= '0;
            base_q   <= base_full[AW-1:0];
`ifdef PD_DW_MC_PEAK_HOLD_EN
            mode_q   <= i_mode;
`endif
            if (sym_cur == SYM_LAST) begin
              sym_cnt  <= '0;
              slot_cnt <= (slot_cur == SLOT_LAST) ? '0 : slot_cur + LW'(1);
            end else begin
              sym_cnt  <= sym_cur + SW'(1);
            end
          end else begin
            samp_cnt <= cnt_cur + CW'(1);
          end
        end
      end
    end
  end

  // ---------------- stage 2: saturating accumulation and holding bank ----------------
  logic [ACC_W-1:0] acc  [NANT];
  logic [ACC_W-1:0] hold [NANT];
  logic [SUMW-1:0]  sum;
  logic             sat_hit;
  logic [ACC_W-1:0] acc_new;

  assign sum     = SUMW'(acc[ant_q]) + SUMW'(p_q);
  assign sat_hit = vld_q && (sum[SUMW-1:ACC_W] != '0);
  assign acc_new = sat_hit ? ACC_MAX : sum[ACC_W-1:0];

  // Accumulate per antenna; a finished symbol is snapshotted (including its last sample) and zeroed.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      for (int a = 0; a < NANT; a++) begin
        acc[a]  <= '0;
        hold[a] <= '0;
      end
      o_sat <= 1'b0;
    end else begin
      if (last_q) begin
        for (int a = 0; a < NANT; a++) begin
          hold[a] <= (NW'(a) == ant_q) ? acc_new : acc[a];
          acc[a]  <= '0;
        end
      end else if (i_fram) begin
        for (int a = 0; a < NANT; a++) acc[a] <= '0;
      end else if (vld_q) begin
        acc[ant_q] <= acc_new;
      end
      if (i_clr)        o_sat <= 1'b0;
      else if (sat_hit) o_sat <= 1'b1;
    end
  end

  // ---------------- write sequencer ----------------
  state_t           state_q, state_d;
  logic [NW-1:0]    idx_q, idx_d;
  logic [AW-1:0]    clr_addr_q, clr_addr_d;
  logic [AW-1:0]    seq_base_q;
  logic             load_seq;
  logic             ram_we;
  logic [AW-1:0]    ram_addr_a;
  logic [ACC_W-1:0] ram_wdata;
`ifdef PD_DW_MC_PEAK_HOLD_EN
  logic             seq_mode_q;
  logic [ACC_W-1:0] ram_a_q;
`endif

  // State register plus sequencer bookkeeping.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      clr_addr_q <= '0;
      seq_base_q <= '0;
`ifdef PD_DW_MC_PEAK_HOLD_EN
      seq_mode_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      clr_addr_q <= clr_addr_d;
      if (load_seq) begin
        seq_base_q <= base_q;
`ifdef PD_DW_MC_PEAK_HOLD_EN
        seq_mode_q <= mode_q;
`endif
      end
    end
  end

  // Next state and RAM port-A control; clear beats everything, a new symbol restarts the sequence.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_addr_d = clr_addr_q;
    load_seq   = 1'b0;
    ram_we     = 1'b0;
    ram_addr_a = seq_base_q + AW'(idx_q);
    ram_wdata  = hold[idx_q];
    o_sym_done = 1'b0;
    o_clr_busy = 1'b0;
    case (state_q)
      S_IDLE: ;
`ifdef PD_DW_MC_PEAK_HOLD_EN
      S_RD: state_d = S_WR;
`endif
      S_WR: begin
        ram_we = 1'b1;
`ifdef PD_DW_MC_PEAK_HOLD_EN
        if (seq_mode_q && (ram_a_q > hold[idx_q])) ram_wdata = ram_a_q;
`endif
        if (idx_q == ANT_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + NW'(1);
`ifdef PD_DW_MC_PEAK_HOLD_EN
          state_d = seq_mode_q ? S_RD : S_WR;
`else
          state_d = S_WR;
`endif
        end
      end
      S_DONE: begin
        o_sym_done = 1'b1;
        state_d    = S_IDLE;
      end
      S_CLR: begin
        o_clr_busy = 1'b1;
        ram_we     = 1'b1;
        ram_addr_a = clr_addr_q;
        ram_wdata  = '0;
        if (clr_addr_q == DEPTH_LAST) state_d = S_IDLE;
        else                          clr_addr_d = clr_addr_q + AW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    if ((state_q != S_CLR) && last_q) begin
      load_seq = 1'b1;
      idx_d    = '0;
`ifdef PD_DW_MC_PEAK_HOLD_EN
      state_d  = mode_q ? S_RD : S_WR;
`else
      state_d  = S_WR;
`endif
    end
    if (i_clr) begin
      load_seq   = 1'b0;
      state_d    = S_CLR;
      clr_addr_d = '0;
    end
  end

  // ---------------- result RAM ----------------
  logic [ACC_W-1:0] mem [DEPTH];
  logic [ACC_W-1:0] rdata_q;

  // Port A: sequencer/clear writes (suppressed under reset) and peak-hold read-back.
  always_ff @(posedge sys_clk) begin
    if (sys_rst && ram_we) mem[ram_addr_a] <= ram_wdata;
`ifdef PD_DW_MC_PEAK_HOLD_EN
    ram_a_q <= mem[ram_addr_a];
`endif
  end

  // Port B: registered external read, old data on collision, zero beyond the RAM.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst)                       rdata_q <= '0;
    else if ({1'b0, i_raddr} < DEPTH_W) rdata_q <= mem[i_raddr];
    else                                rdata_q <= '0;
  end

  assign o_rdata_lo = rdata_q[31:0];
  assign o_rdata_hi = {16'h0000, rdata_q[47:32]};

endmodule
